// File: rtl/hazard_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : hazard_pkg
// Brief  : Shared types, forward-select codes and helpers for hazard_unit_mc.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package hazard_pkg;

  // Execute-stage operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_MD  = 2'b11;

  // Multi-cycle unit occupancy
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // A register takes part in hazards unless it is the hardwired zero register
  function automatic logic is_valid_reg(input logic [31:0] addr, input logic zero_reg);
    return (addr != 32'd0) || !zero_reg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_mc_md_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : md_scoreboard
// Brief  : Multi-cycle unit tracker: latency counter, destination latch and
//          per-register pending bits with same-cycle writeback bypass.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MD_LAT   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [REG_AW-1:0] dest,
  input  logic              advance,
  input  logic [REG_AW-1:0] rd_a,
  input  logic [REG_AW-1:0] rd_b,
  output logic              busy,
  output logic [3:0]        count,
  output logic              wb,
  output logic [REG_AW-1:0] wb_dest,
  output logic              hit_a,
  output logic              hit_b
);

  localparam int         NREG = 1 << REG_AW;
  localparam logic [3:0] LAT  = 4'(MD_LAT);

  md_state_t         state, state_n;
  logic [3:0]        count_q, count_n;
  logic [REG_AW-1:0] dest_q, dest_n;
  logic [NREG-1:0]   sb;
  logic              accept;
  logic              dest_ok;

  // The result retires only on a cycle the pipeline actually advances
  assign wb      = (state == MD_BUSY) && (count_q == 4'd1) && advance;
  assign accept  = start && advance && ((state == MD_IDLE) || wb);
  assign dest_ok = is_valid_reg(32'(dest), ZERO_REG != 0);
  assign busy    = (state == MD_BUSY);
  assign count   = count_q;
  assign wb_dest = dest_q;
  // A bit being cleared this cycle no longer blocks; the MD forward covers it
  assign hit_a   = sb[rd_a] && !(wb && (dest_q == rd_a));
  assign hit_b   = sb[rd_b] && !(wb && (dest_q == rd_b));

  // Next-state: load on accept, count down while advancing, retire at 1
  always_comb begin
    state_n = state;
    count_n = count_q;
    dest_n  = dest_q;
    case (state)
      MD_IDLE: begin
        if (accept) begin
          state_n = MD_BUSY;
          count_n = LAT;
          dest_n  = dest;
        end
      end
      MD_BUSY: begin
        if (advance) begin
          if (count_q == 4'd1) begin
            if (accept) begin
              count_n = LAT;
              dest_n  = dest;
            end else begin
              state_n = MD_IDLE;
              count_n = 4'd0;
            end
          end else begin
            count_n = count_q - 4'd1;
          end
        end
      end
      default: state_n = MD_IDLE;
    endcase
  end

  // State, counter and destination registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MD_IDLE;
      count_q <= 4'd0;
      dest_q  <= '0;
    end else begin
      state   <= state_n;
      count_q <= count_n;
      dest_q  <= dest_n;
    end
  end

  // Pending bits: retire the old destination, then mark a new one (set wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
    end else begin
      if (wb) sb[dest_q] <= 1'b0;
      if (accept && dest_ok) sb[dest] <= 1'b1;
    end
  end

  // Decode-side mdstall must keep a new launch away while an op is mid-flight
  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(start && advance && (state == MD_BUSY) && (count_q > 4'd1)))
    else $error("md_scoreboard: MdStartE while multi-cycle op in flight");

endmodule
`default_nettype wire

// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : hazard_unit_mc
// Brief  : 5-stage pipeline hazard unit with forwarding, load-use/branch
//          stalls, multi-cycle unit scoreboard, memory wait and perf counters.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MD_LAT   = 4,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic              MdOpD,
  input  logic              MdStartE,
  input  logic [REG_AW-1:0] MdDestE,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MdBusy,
  output logic              MdWriteback,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              rs_d_ok, rt_d_ok, rs_e_ok, rt_e_ok;
  logic [3:0]        md_count;
  logic [REG_AW-1:0] md_dest;
  logic              sb_rs, sb_rt;
  logic              lwstall, branchstall, sbstall, mdstall, hz;

  assign rs_d_ok = is_valid_reg(32'(RsD), ZERO_REG != 0);
  assign rt_d_ok = is_valid_reg(32'(RtD), ZERO_REG != 0);
  assign rs_e_ok = is_valid_reg(32'(RsE), ZERO_REG != 0);
  assign rt_e_ok = is_valid_reg(32'(RtE), ZERO_REG != 0);

  md_scoreboard #(
    .REG_AW  (REG_AW),
    .MD_LAT  (MD_LAT),
    .ZERO_REG(ZERO_REG)
  ) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (MdStartE),
    .dest   (MdDestE),
    .advance(MemReadyM),
    .rd_a   (RsD),
    .rd_b   (RtD),
    .busy   (MdBusy),
    .count  (md_count),
    .wb     (MdWriteback),
    .wb_dest(md_dest),
    .hit_a  (sb_rs),
    .hit_b  (sb_rt)
  );

  // Youngest producer wins: MD retire, then Memory, then Writeback
  function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src, input logic src_ok);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src_ok && MdWriteback && (md_dest == src))         sel = FWD_MD;
    else if (src_ok && RegWriteM && (WriteRegM == src))    sel = FWD_MEM;
    else if (src_ok && RegWriteW && (WriteRegW == src))    sel = FWD_WB;
    return sel;
  endfunction

  // Operand forwarding selects for Execute and the Decode branch comparator
  always_comb begin
    ForwardAE = fwd_e(RsE, rs_e_ok);
    ForwardBE = fwd_e(RtE, rt_e_ok);
    ForwardAD = rs_d_ok && RegWriteM && (RsD == WriteRegM);
    ForwardBD = rt_d_ok && RegWriteM && (RtD == WriteRegM);
  end

  // Stall/flush generation; a memory wait freezes every stage
  always_comb begin
    lwstall     = MemtoRegE && rt_e_ok && ((RsD == RtE) || (RtD == RtE));
    branchstall = BranchD &&
                  ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                   (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    sbstall     = (rs_d_ok && sb_rs) || (rt_d_ok && sb_rt);
    mdstall     = MdOpD && MdBusy && (md_count > 4'd1);
    hz          = lwstall | branchstall | sbstall | mdstall;
    StallF = hz;
    StallD = hz;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushE = hz | JumpD;
    FlushW = 1'b0;
    if (!MemReadyM) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end
  end

  // Saturating stall/flush cycle counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != CNT_MAX))            StallCnt <= StallCnt + CNT_W'(1);
      if ((FlushE || FlushW) && (FlushCnt != CNT_MAX)) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_hazard_unit_mc
// Brief  : Directed and randomized checks of hazard_unit_mc against a
//          behavioural model (one op in flight tracked as cycles remaining).
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_hazard_unit_mc;

  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [REG_AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, MdDestE;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic BranchD, JumpD, MdOpD, MdStartE, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD, StallF, StallD, StallE, StallM, FlushE, FlushW;
  logic MdBusy, MdWriteback;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  hazard_unit_mc #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .ZERO_REG(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .JumpD(JumpD), .MdOpD(MdOpD),
    .MdStartE(MdStartE), .MdDestE(MdDestE), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW), .MdBusy(MdBusy), .MdWriteback(MdWriteback),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: the single in-flight op as (cycles remaining, dest)
  int          md_rem = 0;
  logic [4:0]  md_dst = '0;
  int          scnt = 0, fcnt = 0;

  function automatic logic vr(input logic [4:0] a);
    return a != 5'd0;
  endfunction

  function automatic logic [1:0] fwd_model(input logic [4:0] r, input logic retiring);
    if (!vr(r)) return 2'd0;
    if (retiring && md_dst == r) return 2'd3;
    if (RegWriteM && WriteRegM == r) return 2'd2;
    if (RegWriteW && WriteRegW == r) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic pending(input logic [4:0] r, input logic retiring);
    return vr(r) && vr(md_dst) && md_rem > 0 && md_dst == r && !retiring;
  endfunction

  // Compare every output against the model, then advance the model one edge
  task automatic tick();
    logic retiring, lw, br, sb, md, hz;
    logic sf, sd, se, sm, fe, fw;
    #1;
    if (!rst_n) begin md_rem = 0; scnt = 0; fcnt = 0; end
    retiring = MemReadyM && md_rem == 1;
    lw = MemtoRegE && vr(RtE) && (RsD == RtE || RtD == RtE);
    br = BranchD && ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                     (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
    sb = pending(RsD, retiring) || pending(RtD, retiring);
    md = MdOpD && md_rem > 1;
    hz = lw | br | sb | md;
    if (!MemReadyM) begin
      sf = 1; sd = 1; se = 1; sm = 1; fe = 0; fw = 1;
    end else begin
      sf = hz; sd = hz; se = 0; sm = 0; fe = hz | JumpD; fw = 0;
    end
    check_eq("ForwardAE", 32'(ForwardAE), 32'(fwd_model(RsE, retiring)));
    check_eq("ForwardBE", 32'(ForwardBE), 32'(fwd_model(RtE, retiring)));
    check_eq("ForwardAD", 32'(ForwardAD), 32'(vr(RsD) && RegWriteM && RsD == WriteRegM));
    check_eq("ForwardBD", 32'(ForwardBD), 32'(vr(RtD) && RegWriteM && RtD == WriteRegM));
    check_eq("StallF", 32'(StallF), 32'(sf));
    check_eq("StallD", 32'(StallD), 32'(sd));
    check_eq("StallE", 32'(StallE), 32'(se));
    check_eq("StallM", 32'(StallM), 32'(sm));
    check_eq("FlushE", 32'(FlushE), 32'(fe));
    check_eq("FlushW", 32'(FlushW), 32'(fw));
    check_eq("MdBusy", 32'(MdBusy), 32'(md_rem > 0));
    check_eq("MdWriteback", 32'(MdWriteback), 32'(retiring));
    check_eq("StallCnt", 32'(StallCnt), 32'(scnt));
    check_eq("FlushCnt", 32'(FlushCnt), 32'(fcnt));
    @(posedge clk);
    if (rst_n) begin
      if (MemReadyM) begin
        if (md_rem > 0) md_rem--;
        if (MdStartE && md_rem == 0) begin md_rem = MD_LAT; md_dst = MdDestE; end
      end
      if (sf && scnt < CMAX) scnt++;
      if ((fe || fw) && fcnt < CMAX) fcnt++;
    end
    @(negedge clk);
  endtask

  task automatic clr();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, MdDestE} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
    {BranchD, JumpD, MdOpD, MdStartE} = '0;
    MemReadyM = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    @(negedge clk);
    #1 check_eq("rst_busy", 32'(MdBusy), 32'd0);
    check_eq("rst_scnt", 32'(StallCnt), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // E-stage forwarding priority and register 0
    RsE = 5'd3; WriteRegM = 5'd3; WriteRegW = 5'd3; RegWriteM = 1; RegWriteW = 1;
    #1 check_eq("fwd_prio", 32'(ForwardAE), 32'd2);
    tick();
    RsE = 5'd0;
    #1 check_eq("fwd_r0", 32'(ForwardAE), 32'd0);
    tick(); clr();

    // Load-use
    MemtoRegE = 1; RtE = 5'd5; RsD = 5'd5;
    #1 check_eq("lw_stall", 32'({StallF, StallD, FlushE}), 32'd7);
    tick();
    check_eq("lw_cnt", 32'(StallCnt), 32'd1);
    clr();

    // Multi-cycle dependency held in Decode, then bypassed on retire
    MdStartE = 1; MdDestE = 5'd8; tick();
    MdStartE = 0; RsD = 5'd8;
    repeat (3) begin #1 check_eq("md_hold", 32'(StallD), 32'd1); tick(); end
    RsE = 5'd8;
    #1 check_eq("md_release", 32'({StallD, MdWriteback, ForwardAE}), 32'b0111);
    tick(); clr();

    // Back-to-back ops with an MdOpD waiting in Decode
    MdStartE = 1; MdDestE = 5'd9; tick();
    MdStartE = 0; MdOpD = 1; tick();
    repeat (2) begin #1 check_eq("mdstall", 32'(StallD), 32'd1); tick(); end
    MdStartE = 1; MdDestE = 5'd10;
    #1 check_eq("b2b_wb1", 32'({MdWriteback, StallD}), 32'b10);
    tick();
    MdStartE = 0; MdOpD = 0;
    repeat (3) begin #1 check_eq("b2b_gap", 32'({MdBusy, MdWriteback}), 32'b10); tick(); end
    #1 check_eq("b2b_wb2", 32'(MdWriteback), 32'd1);
    tick(); clr();

    // Memory wait during BUSY freezes the count
    MdStartE = 1; MdDestE = 5'd11; tick();
    MdStartE = 0; tick();
    MemReadyM = 0;
    repeat (3) begin
      #1 check_eq("memstall", 32'({StallF, StallD, StallE, StallM, FlushW, FlushE, MdWriteback}), 32'b1111100);
      tick();
    end
    MemReadyM = 1;
    repeat (2) begin #1 check_eq("mem_delay", 32'(MdWriteback), 32'd0); tick(); end
    #1 check_eq("mem_wb", 32'(MdWriteback), 32'd1);
    tick(); clr();

    // Asynchronous reset mid-op
    MdStartE = 1; MdDestE = 5'd12; tick();
    MdStartE = 0; RsD = 5'd12; tick();
    rst_n = 1'b0;
    #1 check_eq("arst", 32'({MdBusy, StallD, StallCnt, FlushCnt}), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) begin #1 check_eq("arst_nowb", 32'(MdWriteback), 32'd0); tick(); end
    clr();

    // Randomized traffic over a small register window to provoke hazards
    repeat (400) begin
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3)); MdDestE = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom_range(0, 3) == 0); MemtoRegM = 1'($urandom_range(0, 3) == 0);
      BranchD = 1'($urandom_range(0, 3) == 0); JumpD = 1'($urandom_range(0, 5) == 0);
      MdOpD = 1'($urandom_range(0, 3) == 0);
      MemReadyM = 1'($urandom_range(0, 4) != 0);
      MdStartE = 1'($urandom_range(0, 2) == 0) && (md_rem <= 1 || !MemReadyM);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
